// File: rtl/packet_receiver_if.sv
// Packet stream and FIFO-slot write bus between the transmit path, the
// packet receiver (slave side) and the input FIFO.
interface packet_receiver_if #(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4
);
   logic                 packet_valid;
   logic [UWIDTH-1:0]    packet_in;
   logic                 wfull;
   logic                 wen;
   logic [PTR_IN_SZ-1:0] waddr;
   logic [UWIDTH-1:0]    wdata;
   logic                 winc;
   logic                 crc_err;
   logic                 len_err;
   logic                 drop;

   modport master (
      output packet_valid, packet_in, wfull,
      input  wen, waddr, wdata, winc, crc_err, len_err, drop
   );

   modport slave (
      input  packet_valid, packet_in, wfull,
      output wen, waddr, wdata, winc, crc_err, len_err, drop
   );
endinterface

// File: rtl/packet_receiver.sv
// Byte-serial packet parser: writes SRC/DST/SIZE/DATA/CRC into one FIFO slot,
// commits the slot only when the XOR CRC matches.
module packet_receiver #(
   parameter int UWIDTH    = 8,
   parameter int PTR_IN_SZ = 4,
   parameter int SIZE_BITS = 3
) (
   input logic               clk,
   input logic               rst,
   packet_receiver_if.slave  bus
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DST  = 3'd1;
   localparam logic [2:0] S_SIZE = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CRC  = 3'd4;
   localparam logic [2:0] S_DROP = 3'd5;

   logic [2:0]           r_state;
   logic [UWIDTH-1:0]    r_crc;
   logic [SIZE_BITS-1:0] r_cnt;
   logic                 r_wen;
   logic [PTR_IN_SZ-1:0] r_waddr;
   logic [UWIDTH-1:0]    r_wdata;
   logic                 r_winc;
   logic                 r_crc_err;
   logic                 r_len_err;
   logic                 r_drop;

   logic                 w_valid;
   logic [UWIDTH-1:0]    w_byte;
   logic [SIZE_BITS-1:0] w_n;
   logic [PTR_IN_SZ-1:0] w_next_addr;

   assign w_valid     = bus.packet_valid;
   assign w_byte      = bus.packet_in;
   assign w_n         = w_byte[SIZE_BITS-1:0];
   // Every byte after SRC lands one address above the previous write.
   assign w_next_addr = r_waddr + 1'b1;

   // NOTE: all state here uses non-blocking assignments so every register
   // sees the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_crc     <= '0;
         r_cnt     <= '0;
         r_wen     <= 1'b0;
         r_waddr   <= '0;
         r_wdata   <= '0;
         r_winc    <= 1'b0;
         r_crc_err <= 1'b0;
         r_len_err <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_wen     <= 1'b0;
         r_winc    <= 1'b0;
         r_crc_err <= 1'b0;
         r_len_err <= 1'b0;
         r_drop    <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_valid) begin
                  if (bus.wfull) begin
                     r_drop  <= 1'b1;
                     r_state <= S_DROP;
                  end else begin
                     r_wen   <= 1'b1;
                     r_waddr <= '0;
                     r_wdata <= w_byte;
                     r_crc   <= w_byte;
                     r_state <= S_DST;
                  end
               end
            end

            S_DST, S_SIZE, S_DATA, S_CRC: begin
               if (!w_valid) begin
                  // Truncated packet: slot is never committed and gets reused.
                  r_len_err <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_wen   <= 1'b1;
                  r_waddr <= w_next_addr;
                  r_wdata <= w_byte;
                  r_crc   <= r_crc ^ w_byte;
                  case (r_state)
                     S_DST: r_state <= S_SIZE;
                     S_SIZE: begin
                        r_cnt   <= w_n;
                        r_state <= (w_n == '0) ? S_CRC : S_DATA;
                     end
                     S_DATA: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == SIZE_BITS'(1)) r_state <= S_CRC;
                     end
                     default: begin
                        if (w_byte == r_crc) r_winc    <= 1'b1;
                        else                 r_crc_err <= 1'b1;
                        r_state <= S_IDLE;
                     end
                  endcase
               end
            end

            S_DROP: begin
               if (!w_valid) r_state <= S_IDLE;
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.wen     = r_wen;
   assign bus.waddr   = r_waddr;
   assign bus.wdata   = r_wdata;
   assign bus.winc    = r_winc;
   assign bus.crc_err = r_crc_err;
   assign bus.len_err = r_len_err;
   assign bus.drop    = r_drop;

endmodule

// File: tb/tb_packet_receiver.sv
// Table-driven bench for packet_receiver: each vector's expected slot writes
// and status pulses go into a scoreboard queue, popped as the DUT reports them.
module tb_packet_receiver;

   localparam int UW = 8;
   localparam int PW = 4;
   localparam int SB = 3;
   localparam int NVEC = 13;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   packet_receiver_if #(.UWIDTH(UW), .PTR_IN_SZ(PW)) bus ();

   packet_receiver #(.UWIDTH(UW), .PTR_IN_SZ(PW), .SIZE_BITS(SB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef enum int {K_COMMIT, K_CRCERR, K_LENERR, K_DROP, K_SILENT} kind_t;

   typedef struct {
      logic [7:0] b [12];
      int         len;
      bit         wfull_src;
      bit         wfull_mid;
      bit         gap;
      kind_t      kind;
   } vec_t;

   typedef struct packed {
      logic       wen;
      logic       winc;
      logic       crc_err;
      logic       len_err;
      logic       drop;
      logic [3:0] waddr;
      logic [7:0] wdata;
   } obs_t;

   obs_t  sb_q[$];
   vec_t  vecs[NVEC];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cur_vec = -1;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic obs_t mk(bit wen, bit winc, bit crce, bit lene, bit drp,
                               logic [3:0] a, logic [7:0] d);
      obs_t o;
      o.wen = wen; o.winc = winc; o.crc_err = crce; o.len_err = lene; o.drop = drp;
      o.waddr = wen ? a : 4'h0;
      o.wdata = wen ? d : 8'h00;
      return o;
   endfunction

   // Bytes are given right-justified in raw, first packet byte most significant.
   function automatic vec_t mk_vec(logic [95:0] raw, int len, bit wfs, bit wfm,
                                   bit gap, kind_t k);
      vec_t v;
      for (int i = 0; i < 12; i++) v.b[i] = 8'h00;
      for (int i = 0; i < len; i++) v.b[i] = raw[(len-1-i)*8 +: 8];
      v.len = len; v.wfull_src = wfs; v.wfull_mid = wfm; v.gap = gap; v.kind = k;
      return v;
   endfunction

   task automatic drive(bit v, logic [7:0] b, bit wf);
      bus.packet_valid = v;
      bus.packet_in    = b;
      bus.wfull        = wf;
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(vec_t t);
      case (t.kind)
         K_DROP:   sb_q.push_back(mk(0, 0, 0, 0, 1, 4'h0, 8'h00));
         K_SILENT: ;
         default: begin
            for (int i = 0; i < t.len; i++)
               sb_q.push_back(mk(1, (t.kind == K_COMMIT) && (i == t.len-1),
                                 (t.kind == K_CRCERR) && (i == t.len-1), 0, 0,
                                 4'(i), t.b[i]));
            if (t.kind == K_LENERR) sb_q.push_back(mk(0, 0, 0, 1, 0, 4'h0, 8'h00));
         end
      endcase
      for (int i = 0; i < t.len; i++)
         drive(1'b1, t.b[i], (i == 0) ? t.wfull_src : t.wfull_mid);
      if (t.gap || t.kind == K_LENERR) drive(1'b0, 8'h00, 1'b0);
   endtask

   // Scoreboard monitor, sampling mid-cycle on the falling edge.
   always @(negedge clk) begin
      obs_t o, e;
      if (rst && (bus.wen || bus.winc || bus.crc_err || bus.len_err || bus.drop)) begin
         o = mk(bus.wen, bus.winc, bus.crc_err, bus.len_err, bus.drop, bus.waddr, bus.wdata);
         if (sb_q.size() == 0) begin
            check($sformatf("vec%0d_unexpected_output", cur_vec), 32'(o), 32'(0));
         end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d_event", cur_vec), 32'(o), 32'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = mk_vec(96'({8'h01, 8'h02, 8'h02, 8'hA5, 8'h3C, 8'h98}), 6, 0, 0, 1, K_COMMIT);
      vecs[1]  = mk_vec(96'({8'h03, 8'h04, 8'h00, 8'h07}), 4, 0, 0, 0, K_COMMIT);
      vecs[2]  = mk_vec(96'({8'h10, 8'h20, 8'h01, 8'h55, 8'h64}), 5, 0, 0, 1, K_COMMIT);
      vecs[3]  = mk_vec(96'({8'h01, 8'h02, 8'h02, 8'hA5, 8'h3C, 8'h99}), 6, 0, 0, 1, K_CRCERR);
      vecs[4]  = mk_vec(96'({8'h01, 8'h02, 8'h02, 8'hA5, 8'h3C, 8'h98}), 6, 1, 1, 1, K_DROP);
      vecs[5]  = mk_vec(96'({8'h01, 8'h02, 8'h02, 8'hA5, 8'h3C, 8'h98}), 6, 0, 0, 1, K_COMMIT);
      vecs[6]  = mk_vec(96'({8'h0A, 8'h0B, 8'h02, 8'hC3}), 4, 0, 0, 0, K_LENERR);
      vecs[7]  = mk_vec(96'({8'h0A, 8'h0B, 8'h02, 8'hC3, 8'h5D, 8'h9D}), 6, 0, 0, 1, K_COMMIT);
      vecs[8]  = mk_vec(96'({8'h11, 8'h22, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                             8'h06, 8'h07, 8'h34}), 11, 0, 0, 1, K_COMMIT);
      vecs[9]  = mk_vec(96'({8'h55, 8'h66, 8'hF9, 8'hAB, 8'h61}), 5, 0, 0, 0, K_COMMIT);
      vecs[10] = mk_vec(96'({8'h01, 8'h02, 8'h00, 8'h03}), 4, 0, 1, 1, K_COMMIT);
      vecs[11] = mk_vec(96'({8'h01, 8'h02, 8'h00, 8'h03}), 4, 1, 0, 0, K_DROP);
      vecs[12] = mk_vec(96'({8'h03, 8'h04, 8'h00, 8'h07}), 4, 0, 0, 1, K_SILENT);

      bus.packet_valid = 1'b0;
      bus.packet_in    = 8'h00;
      bus.wfull        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            32'({bus.wen, bus.winc, bus.crc_err, bus.len_err, bus.drop, bus.waddr, bus.wdata}),
            32'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < NVEC; v++) begin
         cur_vec = v;
         run_vec(vecs[v]);
      end

      // Asynchronous reset while DATA[0] is being written.
      cur_vec = 100;
      sb_q.push_back(mk(1, 0, 0, 0, 0, 4'h0, 8'h21));
      sb_q.push_back(mk(1, 0, 0, 0, 0, 4'h1, 8'h22));
      sb_q.push_back(mk(1, 0, 0, 0, 0, 4'h2, 8'h02));
      drive(1'b1, 8'h21, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      drive(1'b1, 8'h02, 1'b0);
      drive(1'b1, 8'h44, 1'b0);
      #1;
      rst = 1'b0;
      #1;
      check("async_reset_outputs",
            32'({bus.wen, bus.winc, bus.crc_err, bus.len_err, bus.drop, bus.waddr, bus.wdata}),
            32'(0));
      bus.packet_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      cur_vec = 101;
      run_vec(mk_vec(96'({8'h21, 8'h22, 8'h02, 8'h44, 8'h55, 8'h10}), 6, 0, 0, 1, K_COMMIT));

      repeat (4) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(sb_q.size()), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
